fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//  Write-side controller for the async FIFO, generalised successor of the basic write-pointer block.
//  Owns the binary/gray write pointer and has a built-in rptr synchroniser with configurable stages.
//  Provides registered full, almost-full, free-count and sticky overflow flags, all in the wclk domain.
//  Sits between the producer and the dual-port RAM write port; the gray rptr comes raw from the read domain.
// PARAMETERS
//  DEPTH        8  FIFO entries; power of 2, >=4. AW = $clog2(DEPTH).
//  SYNC_STAGES  2  flops in rptr_gray synchroniser; allowed range 2..4.
//  AFULL_FREE   2  walmost_full asserts when free entries <= AFULL_FREE; allowed range 1..DEPTH-1.
// PORTS
//  wclk          in   1     write clock (sole clock)
//  wrst_n        in   1     asynchronous active-low reset
//  winc          in   1     producer write request
//  wovf_clr      in   1     clears woverflow
//  rptr_gray     in   AW+1  read pointer, gray, from read domain (unsynchronised)
//  wptr_gray     out  AW+1  registered gray write pointer, to read domain
//  waddr         out  AW    RAM write address = wbin[AW-1:0]
//  wen_mem       out  1     RAM write enable = winc & ~wfull (comb)
//  wfull         out  1     registered full
//  walmost_full  out  1     registered almost-full
//  wfree         out  AW+1  registered free entries, 0..DEPTH
//  woverflow     out  1     sticky: a write was attempted while full
// BEHAVIOUR
//  Reset (wrst_n low, async): wbin=0, wptr_gray=0, sync flops=0, wfull=0, walmost_full=0,
//   wfree=DEPTH, woverflow=0. wen_mem follows winc, because wfull=0 during reset.
//  Synchroniser: rq_sync = rptr_gray delayed SYNC_STAGES wclk edges; rbin_s = gray2bin(rq_sync).
//  Write accept: at a posedge with winc & ~wfull, wbin_nxt = wbin+1 (mod 2^(AW+1)); otherwise wbin holds.
//   - The data for that write lands at the current waddr.
//  Pointer: wptr_gray <= wbin_nxt ^ (wbin_nxt>>1), registered together with wbin. No comb gray path out.
//  Flags are registered from next-state values so they align with the pointer:
//   - used_nxt = (wbin_nxt - rbin_s) mod 2^(AW+1)
//   - wfree <= DEPTH - used_nxt
//   - wfull <= (used_nxt == DEPTH), i.e. MSBs differ and low AW bits equal
//   - walmost_full <= (DEPTH - used_nxt) <= AFULL_FREE; this also holds while full
//  Latency:
//   - The write that fills the FIFO asserts wfull at that same edge; the next winc is blocked.
//   - An rptr_gray change is reflected in wfull/wfree exactly SYNC_STAGES+1 edges later.
//   - Flags are conservative: a stale rptr only under-reports free space and never causes overflow.
//  Overflow: a posedge with winc & wfull sets woverflow. The pointer is unchanged and wen_mem=0.
//   - wovf_clr clears woverflow. If set and clear occur on the same edge, set wins.
//  Wrap: wbin rolls over 2^(AW+1)-1 -> 0; waddr rolls over DEPTH-1 -> 0. No special casing.
//  Mid-operation reset: all state returns to reset values immediately; any in-flight write is dropped.
//  Elaboration-time error if DEPTH is not a power of 2, or if a parameter is outside its range.
// TESTING (DEPTH=8, SYNC_STAGES=2, AFULL_FREE=2 unless noted)
//  1 Reset, then release -> wfree=8, wfull=0, walmost_full=0, wptr_gray=0, waddr=0, woverflow=0.
//  2 rptr_gray=0, winc high 8 cycles -> waddr 0..7.
//    - walmost_full rises at the 6th write edge (wfree=2); wfull rises at the 8th (wfree=0).
//  3 9th winc while full -> wen_mem=0, waddr stays 0, woverflow=1.
//    - Assert wovf_clr together with a further full write -> woverflow stays 1.
//    - Then wovf_clr alone -> woverflow=0.
//  4 From full, set rptr_gray=4'b0001 (rbin=1) -> wfull falls exactly 3 edges later, wfree=1.
//  5 Stream 20 writes with the reader keeping pace.
//    - Check wptr_gray == bin^(bin>>1) every cycle (e.g. wbin=9 -> 4'b1101).
//    - waddr wraps 7->0 twice; wfull never asserts.
//  6 Assert wrst_n low between clock edges at wfree=3 -> all outputs at reset values before the next edge.
//    - Repeat with SYNC_STAGES=3 and AFULL_FREE=1: the 4-edge release latency and the threshold move accordingly.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: binary/gray write pointer, rptr synchroniser,
// and registered full / almost-full / free-count / sticky overflow flags in the wclk domain.
module fifo_wr_ctrl #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_FREE  = 2,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          wclk,
    input  logic          wrst_n,
    input  logic          winc,
    input  logic          wovf_clr,
    input  logic [AW:0]   rptr_gray,
    output logic [AW:0]   wptr_gray,
    output logic [AW-1:0] waddr,
    output logic          wen_mem,
    output logic          wfull,
    output logic          walmost_full,
    output logic [AW:0]   wfree,
    output logic          woverflow
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AFULL_W = (AW + 1)'(AFULL_FREE);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_wr_ctrl: DEPTH must be a power of 2 and >= 4");
    end
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
        $error("fifo_wr_ctrl: SYNC_STAGES must be in 2..4");
    end
    if ((AFULL_FREE < 1) || (AFULL_FREE > DEPTH - 1)) begin : g_bad_afull
        $error("fifo_wr_ctrl: AFULL_FREE must be in 1..DEPTH-1");
    end

    logic [SYNC_STAGES-1:0][AW:0] sync_q;
    logic [AW:0]                  rq_sync;
    logic [AW:0]                  rbin_s;

    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wgray_q, wgray_d;
    logic [AW:0] wfree_q, wfree_d;
    logic [AW:0] used_nxt;
    logic        wfull_q, wfull_d;
    logic        walmost_full_q, walmost_full_d;
    logic        woverflow_q, woverflow_d;
    logic        accept;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rptr_gray};
        end
    end

    assign rq_sync = sync_q[SYNC_STAGES-1];

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin_s[i] = ^(rq_sync >> i);
        end
    end

    always_comb begin
        accept         = winc & ~wfull_q;
        wbin_d         = wbin_q + {{AW{1'b0}}, accept};
        wgray_d        = wbin_d ^ (wbin_d >> 1);
        used_nxt       = wbin_d - rbin_s;
        wfree_d        = DEPTH_W - used_nxt;
        wfull_d        = (used_nxt == DEPTH_W);
        walmost_full_d = (wfree_d <= AFULL_W);
        // A write attempt while full must win over a simultaneous clear.
        woverflow_d    = (winc & wfull_q) | (woverflow_q & ~wovf_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wgray_q        <= '0;
            wfree_q        <= DEPTH_W;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wgray_q        <= wgray_d;
            wfree_q        <= wfree_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign wptr_gray    = wgray_q;
    assign waddr        = wbin_q[AW-1:0];
    assign wen_mem      = accept;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wfree        = wfree_q;
    assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: two instances (SYNC_STAGES/AFULL_FREE = 2/2 and 3/1) share stimulus;
// directed vector table for fill/overflow/release, then a pointer-count model for streaming and random traffic.
module tb_fifo_wr_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic       wovf_clr;
    logic [3:0] rptr_gray;

    logic [3:0] wptr_gray    [2];
    logic [2:0] waddr        [2];
    logic       wen_mem      [2];
    logic       wfull        [2];
    logic       walmost_full [2];
    logic [3:0] wfree        [2];
    logic       woverflow    [2];

    fifo_wr_ctrl #(.DEPTH(8), .SYNC_STAGES(2), .AFULL_FREE(2)) dut_a (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wovf_clr(wovf_clr), .rptr_gray(rptr_gray),
        .wptr_gray(wptr_gray[0]), .waddr(waddr[0]), .wen_mem(wen_mem[0]), .wfull(wfull[0]),
        .walmost_full(walmost_full[0]), .wfree(wfree[0]), .woverflow(woverflow[0])
    );

    fifo_wr_ctrl #(.DEPTH(8), .SYNC_STAGES(3), .AFULL_FREE(1)) dut_b (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wovf_clr(wovf_clr), .rptr_gray(rptr_gray),
        .wptr_gray(wptr_gray[1]), .waddr(waddr[1]), .wen_mem(wen_mem[1]), .wfull(wfull[1]),
        .walmost_full(walmost_full[1]), .wfree(wfree[1]), .woverflow(woverflow[1])
    );

    always #5 wclk = ~wclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int stages(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int afull_free(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic [3:0] to_gray(input int v);
        logic [3:0] b;
        b = 4'(v % 16);
        return b ^ (b >> 1);
    endfunction

    typedef struct {
        logic       winc;
        logic       clr;
        logic [3:0] rptr;
        logic       wen;
        int         wbin;
        int         free_a;
        logic       full_a;
        logic       af_a;
        logic       ovf;
        int         free_b;
        logic       full_b;
        logic       af_b;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic c, input logic [3:0] r, input logic wen,
                                input int wbin, input int fa, input logic fua, input logic afa,
                                input logic ov, input int fb, input logic fub, input logic afb);
        vec_t v;
        v.winc = w; v.clr = c; v.rptr = r; v.wen = wen; v.wbin = wbin;
        v.free_a = fa; v.full_a = fua; v.af_a = afa; v.ovf = ov;
        v.free_b = fb; v.full_b = fub; v.af_b = afb;
        return v;
    endfunction

    // Reference model: absolute write/read counts; each instance sees the read count
    // that was presented SYNC_STAGES edges before the edge being evaluated.
    int m_wcnt [2];
    int m_free [2];
    bit m_full [2];
    bit m_af   [2];
    bit m_ovf  [2];
    int rcnt;
    int hist[$];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wcnt[k] = 0; m_free[k] = 8; m_full[k] = 0; m_af[k] = 0; m_ovf[k] = 0;
        end
        rcnt = 0;
        hist = '{0, 0, 0, 0, 0};
    endfunction

    task automatic check_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_gray%0d", tag, k), wptr_gray[k], 0);
            check($sformatf("%s_waddr%0d", tag, k), waddr[k], 0);
            check($sformatf("%s_free%0d", tag, k), wfree[k], 8);
            check($sformatf("%s_full%0d", tag, k), wfull[k], 0);
            check($sformatf("%s_afull%0d", tag, k), walmost_full[k], 0);
            check($sformatf("%s_ovf%0d", tag, k), woverflow[k], 0);
            check($sformatf("%s_wen%0d", tag, k), wen_mem[k], winc);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic model_step(input logic w, input logic c);
        int used;
        winc = w; wovf_clr = c; rptr_gray = to_gray(rcnt);
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("m_wen%0d", k), wen_mem[k], w && !m_full[k]);
        @(posedge wclk);
        for (int k = 0; k < 2; k++) begin
            m_ovf[k]   = (w && m_full[k]) || (m_ovf[k] && !c);
            m_wcnt[k] += (w && !m_full[k]) ? 1 : 0;
            used       = m_wcnt[k] - hist[stages(k) - 1];
            m_free[k]  = 8 - used;
            m_full[k]  = (used == 8);
            m_af[k]    = (m_free[k] <= afull_free(k));
        end
        hist.push_front(rcnt);
        if (hist.size() > 5) void'(hist.pop_back());
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("m_gray%0d", k), wptr_gray[k], to_gray(m_wcnt[k]));
            check($sformatf("m_waddr%0d", k), waddr[k], m_wcnt[k] % 8);
            check($sformatf("m_free%0d", k), wfree[k], m_free[k]);
            check($sformatf("m_full%0d", k), wfull[k], m_full[k]);
            check($sformatf("m_afull%0d", k), walmost_full[k], m_af[k]);
            check($sformatf("m_ovf%0d", k), woverflow[k], m_ovf[k]);
        end
        @(negedge wclk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl[15];
        int   wraps;
        int   prev_addr;
        bit   full_seen;
        int   wmin;

        // Fill to full, overflow set/clear, then rptr release with per-instance latency.
        for (int i = 1; i <= 8; i++) begin
            tbl[i-1] = mk(1, 0, 4'b0000, 1, i, 8 - i, i == 8, i >= 6, 0, 8 - i, i == 8, i >= 7);
        end
        tbl[8]  = mk(1, 0, 4'b0000, 0, 8, 0, 1, 1, 1, 0, 1, 1);
        tbl[9]  = mk(1, 1, 4'b0000, 0, 8, 0, 1, 1, 1, 0, 1, 1);
        tbl[10] = mk(0, 1, 4'b0000, 0, 8, 0, 1, 1, 0, 0, 1, 1);
        tbl[11] = mk(0, 0, 4'b0001, 0, 8, 0, 1, 1, 0, 0, 1, 1);
        tbl[12] = mk(0, 0, 4'b0001, 0, 8, 0, 1, 1, 0, 0, 1, 1);
        tbl[13] = mk(0, 0, 4'b0001, 0, 8, 1, 0, 1, 0, 0, 1, 1);
        tbl[14] = mk(0, 0, 4'b0001, 0, 8, 1, 0, 1, 0, 1, 0, 1);

        wrst_n = 1'b0; winc = 1'b0; wovf_clr = 1'b0; rptr_gray = 4'b0000;
        #12;
        check_reset("rst_hold");
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk); #1;
        check_reset("rst_rel");
        @(negedge wclk);

        for (int i = 0; i < 15; i++) begin
            winc = tbl[i].winc; wovf_clr = tbl[i].clr; rptr_gray = tbl[i].rptr;
            #1;
            for (int k = 0; k < 2; k++) check($sformatf("v%0d_wen%0d", i, k), wen_mem[k], tbl[i].wen);
            @(posedge wclk); #1;
            for (int k = 0; k < 2; k++) begin
                check($sformatf("v%0d_gray%0d", i, k), wptr_gray[k], to_gray(tbl[i].wbin));
                check($sformatf("v%0d_waddr%0d", i, k), waddr[k], tbl[i].wbin % 8);
                check($sformatf("v%0d_free%0d", i, k), wfree[k], (k == 0) ? tbl[i].free_a : tbl[i].free_b);
                check($sformatf("v%0d_full%0d", i, k), wfull[k], (k == 0) ? tbl[i].full_a : tbl[i].full_b);
                check($sformatf("v%0d_afull%0d", i, k), walmost_full[k], (k == 0) ? tbl[i].af_a : tbl[i].af_b);
                check($sformatf("v%0d_ovf%0d", i, k), woverflow[k], tbl[i].ovf);
            end
            @(negedge wclk);
        end

        // Reader advances to 3: wfree=3 on both once synchronised, then reset mid-cycle.
        winc = 1'b0; wovf_clr = 1'b0; rptr_gray = to_gray(3);
        repeat (4) begin
            @(posedge wclk);
            @(negedge wclk);
        end
        for (int k = 0; k < 2; k++) begin
            check($sformatf("pre_rst_free%0d", k), wfree[k], 3);
            check($sformatf("pre_rst_afull%0d", k), walmost_full[k], 0);
        end
        #2;
        wrst_n = 1'b0;
        winc   = 1'b1;
        #1;
        check_reset("mid_rst");
        winc = 1'b0; rptr_gray = 4'b0000;
        @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        model_reset();
        @(posedge wclk); #1;
        check_reset("post_rst");
        @(negedge wclk);

        // Streaming with the reader keeping pace.
        wraps = 0; prev_addr = 0; full_seen = 0;
        for (int n = 0; n < 20; n++) begin
            rcnt = (m_wcnt[0] < m_wcnt[1]) ? m_wcnt[0] : m_wcnt[1];
            model_step(1'b1, 1'b0);
            if (waddr[0] == 3'd0 && prev_addr != 0) wraps++;
            prev_addr = waddr[0];
            if (wfull[0] || wfull[1]) full_seen = 1;
        end
        check("stream_wraps", wraps, 2);
        check("stream_no_full", full_seen, 0);

        // Random traffic; the reader never passes what both instances have written.
        for (int n = 0; n < 400; n++) begin
            wmin = (m_wcnt[0] < m_wcnt[1]) ? m_wcnt[0] : m_wcnt[1];
            if (rcnt < wmin && $urandom_range(0, 99) < 45) begin
                rcnt = rcnt + $urandom_range(1, wmin - rcnt);
            end
            model_step($urandom_range(0, 99) < 65, $urandom_range(0, 7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
